// File: rtl/key_debounce_reset.sv
// Push-button conditioning for the Apple 1 board top: per-key two-flop sync and debounce,
// press/release pulses, and a stretched active-low system reset driven by one key.
module key_debounce_lane #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk25,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_db,
   output logic key_press,
   output logic key_release
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1, sync_2;
   logic          sync;
   logic [CW-1:0] cnt;

   // Flops hold the raw (active-low) level so reset means "released".
   assign sync = ~sync_2;

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         sync_1      <= 1'b1;
         sync_2      <= 1'b1;
         cnt         <= '0;
         key_db      <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         sync_1      <= key_raw;
         sync_2      <= sync_1;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         if (sync == key_db) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt         <= '0;
            key_db      <= ~key_db;
            key_press   <= ~key_db;
            key_release <= key_db;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module key_debounce_reset #(
   parameter int NUM_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES   = 250000,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int RESET_KEY         = 0
) (
   input  logic                clk25,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] keys_db,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                sys_rst_n
);
   localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD = HW'(RESET_HOLD_CYCLES);

   logic [HW-1:0] hold_cnt;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
      key_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
         .clk25       (clk25),
         .rst_n       (rst_n),
         .key_raw     (key_raw[k]),
         .key_db      (keys_db[k]),
         .key_press   (key_press[k]),
         .key_release (key_release[k])
      );
   end

   // Holding the reset key keeps reloading the counter, so the hold restarts on re-press.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= HOLD;
         sys_rst_n <= 1'b0;
      end else if (keys_db[RESET_KEY]) begin
         hold_cnt  <= HOLD;
         sys_rst_n <= 1'b0;
      end else if (hold_cnt > HW'(1)) begin
         hold_cnt  <= hold_cnt - 1'b1;
      end else if (hold_cnt == HW'(1)) begin
         hold_cnt  <= '0;
         sys_rst_n <= 1'b1;
      end
   end
endmodule

// File: tb/tb_key_debounce_reset.sv
// Directed bench for key_debounce_reset with DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4.
module tb_key_debounce_reset;
   logic       clk25 = 1'b0;
   logic       rst_n;
   logic [3:0] key_raw;
   logic [3:0] keys_db, key_press, key_release;
   logic       sys_rst_n;
   int         checks = 0;
   int         errors = 0;
   logic       acc;

   key_debounce_reset #(
      .NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(4), .RESET_KEY(0)
   ) dut (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .key_raw     (key_raw),
      .keys_db     (keys_db),
      .key_press   (key_press),
      .key_release (key_release),
      .sys_rst_n   (sys_rst_n)
   );

   always #5 clk25 = ~clk25;

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk25);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      key_raw = 4'hF;
      #12;
      chk("rst_db",   32'(keys_db), 32'h0);
      chk("rst_pr",   32'(key_press), 32'h0);
      chk("rst_rl",   32'(key_release), 32'h0);
      chk("rst_sys",  32'(sys_rst_n), 32'h0);

      // Power-up hold
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("pwr_e3_sys", 32'(sys_rst_n), 32'h0);
      step(1);
      chk("pwr_e4_sys", 32'(sys_rst_n), 32'h1);
      chk("pwr_db",     32'(keys_db), 32'h0);
      chk("pwr_pr",     32'(key_press), 32'h0);

      // Clean press on key 2
      key_raw = 4'hB;
      step(9);
      chk("k2_e8_db",  32'(keys_db), 32'h0);
      step(1);
      chk("k2_e9_db",  32'(keys_db), 32'h4);
      chk("k2_e9_pr",  32'(key_press), 32'h4);
      chk("k2_e9_sys", 32'(sys_rst_n), 32'h1);
      step(1);
      chk("k2_e10_pr", 32'(key_press), 32'h0);
      chk("k2_e10_db", 32'(keys_db), 32'h4);

      // Bouncing key 1: 5 low / 1 high, ten times
      acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key_raw[1] = 1'b0;
         for (int j = 0; j < 5; j++) begin
            step(1);
            acc = acc | key_press[1] | keys_db[1];
         end
         key_raw[1] = 1'b1;
         step(1);
         acc = acc | key_press[1] | keys_db[1];
      end
      chk("k1_bounce", 32'(acc), 32'h0);
      key_raw[1] = 1'b0;
      step(9);
      chk("k1_e8_db", 32'(keys_db), 32'h4);
      step(1);
      chk("k1_e9_db", 32'(keys_db), 32'h6);
      chk("k1_e9_pr", 32'(key_press), 32'h2);

      // Release keys 1 and 2 together
      key_raw = 4'hF;
      step(10);
      chk("rel12_db", 32'(keys_db), 32'h0);
      chk("rel12_rl", 32'(key_release), 32'h6);
      step(1);
      chk("rel12_rl_off", 32'(key_release), 32'h0);

      // Reset key: press, hold 20 cycles, release
      key_raw = 4'hE;
      step(10);
      chk("k0_M_db",   32'(keys_db), 32'h1);
      chk("k0_M_pr",   32'(key_press), 32'h1);
      chk("k0_M_sys",  32'(sys_rst_n), 32'h1);
      step(1);
      chk("k0_M1_sys", 32'(sys_rst_n), 32'h0);
      chk("k0_M1_pr",  32'(key_press), 32'h0);
      step(10);
      key_raw = 4'hF;
      step(10);
      chk("k0_N_db",   32'(keys_db), 32'h0);
      chk("k0_N_rl",   32'(key_release), 32'h1);
      chk("k0_N_sys",  32'(sys_rst_n), 32'h0);
      step(1);
      chk("k0_N1_rl",  32'(key_release), 32'h0);
      step(2);
      chk("k0_N3_sys", 32'(sys_rst_n), 32'h0);
      step(1);
      chk("k0_N4_sys", 32'(sys_rst_n), 32'h1);

      // Keys 0 and 3 on the same edge
      key_raw = 4'h6;
      step(10);
      chk("k03_pr", 32'(key_press), 32'h9);
      chk("k03_db", 32'(keys_db), 32'h9);
      key_raw = 4'hF;
      step(10);
      chk("k03_rl", 32'(key_release), 32'h9);
      step(4);
      chk("k03_sys", 32'(sys_rst_n), 32'h1);

      // rst_n mid-debounce (count 5 on key 2)
      key_raw = 4'hB;
      step(7);
      rst_n = 1'b0;
      #1;
      chk("mid_db_db",  32'(keys_db), 32'h0);
      chk("mid_db_sys", 32'(sys_rst_n), 32'h0);
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("mid_db_e3_sys", 32'(sys_rst_n), 32'h0);
      step(1);
      chk("mid_db_e4_sys", 32'(sys_rst_n), 32'h1);
      step(5);
      chk("mid_db_e8_db", 32'(keys_db), 32'h0);
      step(1);
      chk("mid_db_e9_db", 32'(keys_db), 32'h4);

      // rst_n during hold count 2
      key_raw = 4'hE;
      step(11);
      chk("hold_pre_sys", 32'(sys_rst_n), 32'h0);
      key_raw = 4'hF;
      step(12);
      chk("hold_N2_sys", 32'(sys_rst_n), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("hold_rst_sys", 32'(sys_rst_n), 32'h0);
      chk("hold_rst_db",  32'(keys_db), 32'h0);
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("hold_e3_sys", 32'(sys_rst_n), 32'h0);
      step(1);
      chk("hold_e4_sys", 32'(sys_rst_n), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
